// File: rtl/rv32_icache.sv
// rv32_icache: direct-mapped, read-only instruction cache between core fetch and instruction memory.
// Latency: hits return instr_bus combinationally in the same cycle; a miss costs one lookup cycle,
//          then one cycle per refill word (more if memory is slow), then one re-lookup cycle.
// Backpressure: instr_ready=0 stalls fetch while a miss/refill is in progress;
//               mem_req is held until mem_rvalid completes each word.
// Ports:
//   clk, resetn      clock (rising edge) and synchronous active-low reset
//   flush            single-cycle pulse that invalidates every line (fence.i)
//   instr_addr       core fetch address, bits [1:0] ignored
//   instr_bus        instruction for instr_addr, NOP (addi x0,x0,0) whenever instr_ready=0
//   instr_ready      instr_bus is valid for instr_addr this cycle
//   mem_req/addr     refill word request and its word address; held until mem_rvalid
//   mem_rdata/rvalid refill data and its strobe; mem_rvalid completes the current request
module rv32_icache #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_bus,
    output logic        instr_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REFILL = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Storage arrays: flops with asynchronous read. Only the valid bits are reset.
    logic [TAG_W-1:0] r_tag_arr [LINES];
    logic [31:0]      r_data    [LINES][LINE_WORDS];
    logic [LINES-1:0] r_valid;

    // Refill bookkeeping.
    logic [TAG_W-1:0] r_refill_tag;
    logic [IDX_W-1:0] r_refill_idx;
    logic [OFF_W-1:0] r_word_cnt;
    logic             r_flush_seen;

    // Address split.
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic [OFF_W-1:0] w_off;

    assign w_tag = instr_addr[31 -: TAG_W];
    assign w_idx = instr_addr[OFF_W+2 +: IDX_W];
    // Shift-and-truncate so the byte-offset bits are consumed without a dangling slice.
    assign w_off = OFF_W'(instr_addr[OFF_W+1:0] >> 2);

    logic w_hit;
    logic w_last;
    logic w_start;
    logic w_fill;
    logic w_done;

    assign w_hit   = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
    assign w_last  = (r_word_cnt == OFF_W'(LINE_WORDS - 1));
    // A flush cycle never starts a refill: the core sees ready=0 and the
    // following lookup (against the now-empty cache) starts the refill.
    assign w_start = (r_state == S_IDLE) && !flush && !w_hit;
    // Responses outside REFILL are stale (e.g. left over from before a reset) and are dropped.
    assign w_fill  = (r_state == S_REFILL) && mem_rvalid;
    assign w_done  = w_fill && w_last;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and outputs.
    always_comb begin
        w_state_nxt = r_state;
        instr_ready = 1'b0;
        instr_bus   = INSTR_NOP;
        mem_req     = 1'b0;
        mem_addr    = 32'h0;
        case (r_state)
            S_IDLE: begin
                // flush beats hit: the line may be stale after self-modifying code.
                if (!flush && w_hit) begin
                    instr_ready = 1'b1;
                    instr_bus   = r_data[w_idx][w_off];
                end
                if (w_start) begin
                    w_state_nxt = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {r_refill_tag, r_refill_idx, r_word_cnt, 2'b00};
                if (mem_rvalid && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Valid bits, word counter and flush tracking (reset).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid      <= '0;
            r_word_cnt   <= '0;
            r_flush_seen <= 1'b0;
        end else begin
            if (w_start) begin
                // The line being replaced is invalid from the first refill write onward.
                r_valid[w_idx] <= 1'b0;
                r_word_cnt     <= '0;
                r_flush_seen   <= 1'b0;
            end
            if (w_fill) begin
                r_word_cnt <= r_word_cnt + OFF_W'(1);
            end
            if (flush) begin
                r_valid <= '0;
                if (r_state == S_REFILL) begin
                    r_flush_seen <= 1'b1;
                end
            end
            // Placed last so it wins over the blanket flush clear; it still writes 0 when
            // a flush arrived at any point during (or on the last beat of) this refill.
            if (w_done) begin
                r_valid[r_refill_idx] <= !(r_flush_seen || flush);
            end
        end
    end

    // Data/tag arrays and refill target (not reset; writes suppressed while resetn=0).
    always_ff @(posedge clk) begin
        if (resetn && w_start) begin
            r_refill_tag <= w_tag;
            r_refill_idx <= w_idx;
        end
        if (resetn && w_fill) begin
            r_data[r_refill_idx][r_word_cnt] <= mem_rdata;
        end
        if (resetn && w_done) begin
            r_tag_arr[r_refill_idx] <= r_refill_tag;
        end
    end

endmodule
